// File: rtl/pool_feature_buffer.sv
// pool_feature_buffer: captures a 13x13x3 pooled frame and replays it channel-major over valid/ready.
// Define POOL_BUF_PINGPONG_EN for two frame banks so filling and draining overlap.
module pool_feature_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int POOL_WIDTH = 13,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] feat_data,
  output logic                  feat_valid,
  input  logic                  feat_ready,
  output logic                  feat_last,
  output logic [ADDR_WIDTH+1:0] feat_index,
  output logic                  drop_err
);
  localparam int NPIX = POOL_WIDTH * POOL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PIX_MAX = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH+1:0] IDX_MAX = (ADDR_WIDTH + 2)'(3 * NPIX - 1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
`ifdef POOL_BUF_PINGPONG_EN
  localparam int NB = 2;
  localparam int RW = ADDR_WIDTH + 1;
`else
  localparam int NB = 1;
  localparam int RW = ADDR_WIDTH;
`endif
  logic [DATA_WIDTH-1:0] ram1 [2**RW];
  logic [DATA_WIDTH-1:0] ram2 [2**RW];
  logic [DATA_WIDTH-1:0] ram3 [2**RW];
  logic [DATA_WIDTH-1:0] q1, q2, q3, p1_data, s_data;
  logic [NB-1:0] bank_st;
  logic fb, db;
  logic [RW-1:0] wa, ra;
  logic [ADDR_WIDTH-1:0] wr_pix, rd_pix;
  logic [1:0] rd_ch, p1_ch, occ;
  logic [ADDR_WIDTH+1:0] rd_idx, p1_idx, s_idx;
  logic rd_done, p1_v, p1_last, s_v, s_last;
  logic pop, pop_last, wr_ok, wr, issue;
`ifdef POOL_BUF_PINGPONG_EN
  assign wa = {fb, wr_pix};
  assign ra = {db, rd_pix};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb <= 1'b0;
      db <= 1'b0;
    end else begin
      if (wr && wr_pix == PIX_MAX) fb <= ~fb;
      if (pop_last) db <= ~db;
    end
  end
`else
  assign wa = wr_pix;
  assign ra = rd_pix;
  assign fb = 1'b0;
  assign db = 1'b0;
`endif
  assign pop = feat_valid && feat_ready;
  assign pop_last = pop && feat_last;
  // a bank being released by the final handshake may take pixel 0 on that same edge
  assign wr_ok = bank_st[fb] == FILL || (pop_last && db == fb);
  assign wr = data_in_valid && wr_ok;
  // reads in flight plus held words never exceed the output register and its skid slot
  assign occ = {1'b0, p1_v} + {1'b0, feat_valid} + {1'b0, s_v};
  assign issue = bank_st[db] == DRAIN && !rd_done && occ < ({1'b0, pop} + 2'd2);
  assign p1_data = p1_ch == 2'd0 ? q1 : p1_ch == 2'd1 ? q2 : q3;
  always_ff @(posedge clk) begin
    if (wr) begin
      ram1[wa] <= data_in_1;
      ram2[wa] <= data_in_2;
      ram3[wa] <= data_in_3;
    end
    q1 <= ram1[ra];
    q2 <= ram2[ra];
    q3 <= ram3[ra];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st <= '0;
      wr_pix <= '0;
      rd_pix <= '0;
      rd_ch <= '0;
      rd_idx <= '0;
      rd_done <= 1'b0;
      p1_v <= 1'b0;
      p1_ch <= '0;
      p1_idx <= '0;
      p1_last <= 1'b0;
      s_v <= 1'b0;
      s_data <= '0;
      s_idx <= '0;
      s_last <= 1'b0;
      feat_valid <= 1'b0;
      feat_data <= '0;
      feat_index <= '0;
      feat_last <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (data_in_valid && !wr_ok) drop_err <= 1'b1;
      if (pop_last) bank_st[db] <= FILL;
      if (wr) wr_pix <= wr_pix == PIX_MAX ? '0 : wr_pix + 1'b1;
      if (wr && wr_pix == PIX_MAX) bank_st[fb] <= DRAIN;
      if (pop_last) begin
        rd_pix <= '0;
        rd_ch <= '0;
        rd_idx <= '0;
        rd_done <= 1'b0;
      end else if (issue) begin
        rd_pix <= rd_pix == PIX_MAX ? '0 : rd_pix + 1'b1;
        rd_ch <= rd_pix == PIX_MAX ? rd_ch + 1'b1 : rd_ch;
        rd_idx <= rd_idx + 1'b1;
        rd_done <= rd_idx == IDX_MAX;
      end
      p1_v <= issue;
      p1_ch <= rd_ch;
      p1_idx <= rd_idx;
      p1_last <= rd_idx == IDX_MAX;
      if (pop || !feat_valid) begin
        if (s_v) begin
          feat_valid <= 1'b1;
          feat_data <= s_data;
          feat_index <= s_idx;
          feat_last <= s_last;
          s_v <= p1_v;
          s_data <= p1_data;
          s_idx <= p1_idx;
          s_last <= p1_last;
        end else begin
          feat_valid <= p1_v;
          feat_last <= p1_v && p1_last;
          if (p1_v) begin
            feat_data <= p1_data;
            feat_index <= p1_idx;
          end
        end
      end else if (p1_v) begin
        s_v <= 1'b1;
        s_data <= p1_data;
        s_idx <= p1_idx;
        s_last <= p1_last;
      end
    end
  end
endmodule
